// File: rtl/tl_channel_buffer.sv
// TileLink A/D channel buffer: two independent FIFOs with optional flow-through and pipelined-full accept.
// Latency 1 cycle (0 with FLOW on an empty queue); in_ready drops when full unless PIPE and out_ready.

module tl_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_bits,
  output logic [CNT_W-1:0] count
);
  localparam bit FLOW_B = (FLOW != 0);
  localparam bit PIPE_B = (PIPE != 0);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             empty, full, bypass, do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign in_ready  = !full || (PIPE_B && out_ready);
  assign out_valid = !empty || (FLOW_B && in_valid);
  assign out_bits  = (FLOW_B && empty) ? in_bits : mem[rd_ptr];

  // A beat that flows straight through an empty queue is never written to storage.
  assign bypass  = FLOW_B && empty && out_ready;
  assign do_push = in_valid && in_ready && !bypass;
  assign do_pop  = out_ready && !empty;

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= in_bits;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end
endmodule

module tl_channel_buffer #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int SRC_W   = 3,
  parameter int SIZE_W  = 2,
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int FLOW    = 0,
  parameter int PIPE    = 0,
  localparam int A_W = 3 + 3 + SIZE_W + SRC_W + ADDR_W + DATA_W / 8 + DATA_W + 1,
  localparam int D_W = 3 + 2 + SIZE_W + SRC_W + 1 + 1 + DATA_W + 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           a_in_valid,
  output logic                           a_in_ready,
  input  logic [A_W-1:0]                 a_in_bits,
  output logic                           a_out_valid,
  input  logic                           a_out_ready,
  output logic [A_W-1:0]                 a_out_bits,
  input  logic                           d_in_valid,
  output logic                           d_in_ready,
  input  logic [D_W-1:0]                 d_in_bits,
  output logic                           d_out_valid,
  input  logic                           d_out_ready,
  output logic [D_W-1:0]                 d_out_bits,
  output logic [$clog2(A_DEPTH+1)-1:0]   a_count,
  output logic [$clog2(D_DEPTH+1)-1:0]   d_count,
  output logic                           idle
);
  tl_fifo #(.W(A_W), .DEPTH(A_DEPTH), .FLOW(FLOW), .PIPE(PIPE)) u_a_fifo (
    .clock(clock), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bits(a_in_bits),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_bits(a_out_bits),
    .count(a_count)
  );

  tl_fifo #(.W(D_W), .DEPTH(D_DEPTH), .FLOW(FLOW), .PIPE(PIPE)) u_d_fifo (
    .clock(clock), .reset(reset),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_bits(d_in_bits),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_bits(d_out_bits),
    .count(d_count)
  );

  assign idle = (a_count == '0) && (d_count == '0);
endmodule

// File: tb/tb_tl_channel_buffer.sv
// Bench for tl_channel_buffer: a plain instance (A depth 2, D depth 3) and a FLOW+PIPE instance,
// checked by per-channel scoreboards plus a vector table and directed corner sequences.
module tb_tl_channel_buffer;
  localparam int AW = 63;
  localparam int DW = 45;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic          a0_iv, a0_ir, a0_ov, a0_or, d0_iv, d0_ir, d0_ov, d0_or, idle0;
  logic [AW-1:0] a0_ib, a0_ob;
  logic [DW-1:0] d0_ib, d0_ob;
  logic [1:0]    a0_cnt, d0_cnt;
  logic          a1_iv, a1_ir, a1_ov, a1_or, d1_iv, d1_ir, d1_ov, d1_or, idle1;
  logic [AW-1:0] a1_ib, a1_ob;
  logic [DW-1:0] d1_ib, d1_ob;
  logic [1:0]    a1_cnt, d1_cnt;

  tl_channel_buffer #(.A_DEPTH(2), .D_DEPTH(3), .FLOW(0), .PIPE(0)) dut0 (
    .clock(clock), .reset(reset),
    .a_in_valid(a0_iv), .a_in_ready(a0_ir), .a_in_bits(a0_ib),
    .a_out_valid(a0_ov), .a_out_ready(a0_or), .a_out_bits(a0_ob),
    .d_in_valid(d0_iv), .d_in_ready(d0_ir), .d_in_bits(d0_ib),
    .d_out_valid(d0_ov), .d_out_ready(d0_or), .d_out_bits(d0_ob),
    .a_count(a0_cnt), .d_count(d0_cnt), .idle(idle0)
  );

  tl_channel_buffer #(.A_DEPTH(2), .D_DEPTH(2), .FLOW(1), .PIPE(1)) dut1 (
    .clock(clock), .reset(reset),
    .a_in_valid(a1_iv), .a_in_ready(a1_ir), .a_in_bits(a1_ib),
    .a_out_valid(a1_ov), .a_out_ready(a1_or), .a_out_bits(a1_ob),
    .d_in_valid(d1_iv), .d_in_ready(d1_ir), .d_in_bits(d1_ib),
    .d_out_valid(d1_ov), .d_out_ready(d1_or), .d_out_bits(d1_ob),
    .a_count(a1_cnt), .d_count(d1_cnt), .idle(idle1)
  );

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] aq0[$], aq1[$];
  logic [DW-1:0] dq0[$], dq1[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] mk_a(input logic [14:0] addr, input logic [31:0] data);
    return {3'd4, 3'd0, 2'd2, 3'd1, addr, 4'hF, data, 1'b0};
  endfunction

  function automatic logic [DW-1:0] mk_d(input logic [2:0] src, input logic [31:0] data);
    return {3'd1, 2'd0, 2'd2, src, 1'b0, 1'b0, data, 1'b0};
  endfunction

  // Counts are compared against scoreboard depth before this cycle's push/pop.
  always @(negedge clock) begin
    if (!reset) begin
      chk("a0 count", 64'(a0_cnt), 64'(aq0.size()));
      chk("d0 count", 64'(d0_cnt), 64'(dq0.size()));
      chk("a1 count", 64'(a1_cnt), 64'(aq1.size()));
      chk("d1 count", 64'(d1_cnt), 64'(dq1.size()));
      chk("idle0", 64'(idle0), 64'(aq0.size() == 0 && dq0.size() == 0));
      if (a0_iv && a0_ir) aq0.push_back(a0_ib);
      if (d0_iv && d0_ir) dq0.push_back(d0_ib);
      if (a1_iv && a1_ir) aq1.push_back(a1_ib);
      if (d1_iv && d1_ir) dq1.push_back(d1_ib);
      if (a0_ov) begin
        if (aq0.size() == 0) chk("a0 valid with nothing queued", 64'(aq0.size()), 64'd1);
        else begin
          chk("a0 out bits", 64'(a0_ob), 64'(aq0[0]));
          if (a0_or) void'(aq0.pop_front());
        end
      end
      if (d0_ov) begin
        if (dq0.size() == 0) chk("d0 valid with nothing queued", 64'(dq0.size()), 64'd1);
        else begin
          chk("d0 out bits", 64'(d0_ob), 64'(dq0[0]));
          if (d0_or) void'(dq0.pop_front());
        end
      end
      if (a1_ov) begin
        if (aq1.size() == 0) chk("a1 valid with nothing queued", 64'(aq1.size()), 64'd1);
        else begin
          chk("a1 out bits", 64'(a1_ob), 64'(aq1[0]));
          if (a1_or) void'(aq1.pop_front());
        end
      end
      if (d1_ov) begin
        if (dq1.size() == 0) chk("d1 valid with nothing queued", 64'(dq1.size()), 64'd1);
        else begin
          chk("d1 out bits", 64'(d1_ob), 64'(dq1[0]));
          if (d1_or) void'(dq1.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic        iv;
    logic        orr;
    logic [14:0] addr;
    logic [31:0] data;
    logic        exp_ir;
    logic        exp_ov;
    logic [1:0]  exp_cnt;
  } row_t;

  row_t tbl[11];

  initial begin
    int sent;
    int cyc;

    tbl[0]  = '{1'b1, 1'b0, 15'h0001, 32'h1111_0001, 1'b1, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 1'b0, 15'h0002, 32'h2222_0002, 1'b1, 1'b1, 2'd1};
    tbl[2]  = '{1'b1, 1'b0, 15'h0003, 32'h3333_0003, 1'b0, 1'b1, 2'd2};
    tbl[3]  = '{1'b1, 1'b0, 15'h0003, 32'h3333_0003, 1'b0, 1'b1, 2'd2};
    tbl[4]  = '{1'b1, 1'b1, 15'h0003, 32'h3333_0003, 1'b0, 1'b1, 2'd2};
    tbl[5]  = '{1'b1, 1'b1, 15'h0003, 32'h3333_0003, 1'b1, 1'b1, 2'd1};
    tbl[6]  = '{1'b0, 1'b1, 15'h0000, 32'h0,         1'b1, 1'b1, 2'd1};
    tbl[7]  = '{1'b0, 1'b1, 15'h0000, 32'h0,         1'b1, 1'b0, 2'd0};
    tbl[8]  = '{1'b1, 1'b1, 15'h0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd0};
    tbl[9]  = '{1'b0, 1'b1, 15'h0000, 32'h0,         1'b1, 1'b1, 2'd1};
    tbl[10] = '{1'b0, 1'b1, 15'h0000, 32'h0,         1'b1, 1'b0, 2'd0};

    {a0_iv, a0_or, d0_iv, d0_or, a1_iv, a1_or, d1_iv, d1_or} = '0;
    a0_ib = '0; d0_ib = '0; a1_ib = '0; d1_ib = '0;

    // Reset state; with FLOW the output valid tracks the input valid even in reset.
    repeat (2) @(posedge clock);
    #1;
    a1_iv = 1'b1;
    #1;
    chk("rst a0 count", 64'(a0_cnt), 64'd0);
    chk("rst a0 in_ready", 64'(a0_ir), 64'd1);
    chk("rst d0 in_ready", 64'(d0_ir), 64'd1);
    chk("rst a0 out_valid", 64'(a0_ov), 64'd0);
    chk("rst idle0", 64'(idle0), 64'd1);
    chk("rst a1 flow valid", 64'(a1_ov), 64'd1);
    a1_iv = 1'b0;
    @(posedge clock);
    #1 reset = 1'b0;

    foreach (tbl[i]) begin
      @(posedge clock);
      #1;
      a0_iv = tbl[i].iv;
      a0_or = tbl[i].orr;
      a0_ib = mk_a(tbl[i].addr, tbl[i].data);
      @(negedge clock);
      chk($sformatf("tbl[%0d] a_in_ready", i), 64'(a0_ir), 64'(tbl[i].exp_ir));
      chk($sformatf("tbl[%0d] a_out_valid", i), 64'(a0_ov), 64'(tbl[i].exp_ov));
      chk($sformatf("tbl[%0d] a_count", i), 64'(a0_cnt), 64'(tbl[i].exp_cnt));
    end
    @(posedge clock);
    #1 a0_iv = 1'b0;

    // Depth-3 D queue: ten beats with random output stalls, wrapping the pointers.
    sent = 0;
    cyc  = 0;
    while (sent < 10 && cyc < 400) begin
      @(posedge clock);
      #1;
      d0_iv = 1'b1;
      d0_ib = mk_d(3'(sent), 32'hC0DE_0000 + 32'(sent));
      d0_or = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (d0_ir) sent++;
      cyc++;
    end
    chk("d0 stream beats accepted", 64'(sent), 64'd10);
    @(posedge clock);
    #1;
    d0_iv = 1'b0;
    d0_or = 1'b1;
    repeat (5) @(posedge clock);
    #1 chk("d0 stream drained", 64'(d0_cnt), 64'd0);

    // PIPE: full queue still accepts when its head pops in the same cycle.
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      a1_iv = 1'b1;
      a1_or = 1'b0;
      a1_ib = mk_a(15'(16'h100 + k), 32'hA1A1_0000 + 32'(k));
    end
    @(posedge clock);
    #1;
    a1_ib = mk_a(15'h0102, 32'hA1A1_0002);
    a1_or = 1'b1;
    @(negedge clock);
    chk("pipe full count", 64'(a1_cnt), 64'd2);
    chk("pipe full in_ready", 64'(a1_ir), 64'd1);
    @(posedge clock);
    #1 a1_iv = 1'b0;
    @(negedge clock);
    chk("pipe count after push+pop", 64'(a1_cnt), 64'd2);
    repeat (3) @(posedge clock);
    #1 a1_or = 1'b0;

    // FLOW: empty queue forwards a beat combinationally without storing it.
    @(posedge clock);
    #1;
    d1_iv = 1'b1;
    d1_or = 1'b1;
    d1_ib = mk_d(3'd5, 32'hF10F_0005);
    #1;
    chk("flow d_out_valid", 64'(d1_ov), 64'd1);
    chk("flow source", 64'(d1_ob[35 +: 3]), 64'd5);
    @(posedge clock);
    #1 d1_iv = 1'b0;
    chk("flow count stays 0", 64'(d1_cnt), 64'd0);

    // Asynchronous reset in the middle of a cycle with two beats resident.
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      a0_iv = 1'b1;
      a0_or = 1'b0;
      a0_ib = mk_a(15'(16'h200 + k), 32'hBEEF_0000 + 32'(k));
    end
    @(posedge clock);
    #1 a0_iv = 1'b0;
    @(negedge clock);
    chk("pre-reset a0 count", 64'(a0_cnt), 64'd2);
    #2 reset = 1'b1;
    aq0.delete(); dq0.delete(); aq1.delete(); dq1.delete();
    #1;
    chk("async rst a0 count", 64'(a0_cnt), 64'd0);
    chk("async rst a0 out_valid", 64'(a0_ov), 64'd0);
    chk("async rst idle0", 64'(idle0), 64'd1);
    chk("async rst a0 in_ready", 64'(a0_ir), 64'd1);
    @(posedge clock);
    #1 reset = 1'b0;

    // First edge after reset accepts normally; scoreboard checks the emerging beat.
    a0_iv = 1'b1;
    a0_or = 1'b1;
    a0_ib = mk_a(15'h0300, 32'h5EED_0300);
    @(negedge clock);
    chk("post-reset in_ready", 64'(a0_ir), 64'd1);
    @(posedge clock);
    #1 a0_iv = 1'b0;
    @(negedge clock);
    chk("post-reset out_valid", 64'(a0_ov), 64'd1);

    cyc = 0;
    while ((aq0.size() + dq0.size() + aq1.size() + dq1.size()) != 0 && cyc < 50) begin
      a0_or = 1'b1; d0_or = 1'b1; a1_or = 1'b1; d1_or = 1'b1;
      @(posedge clock);
      cyc++;
    end
    #1 chk("scoreboards empty", 64'(aq0.size() + dq0.size() + aq1.size() + dq1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tl_channel_buffer.md
TL_CHANNEL_BUFFER -- requirements
Module: tl_channel_buffer

Interface
REQ-001 Parameter ADDR_W, default 15, A-channel address width.
REQ-002 Parameter DATA_W, default 32, data width; SHALL be a multiple of 8.
REQ-003 Parameter SRC_W, default 3, source ID width.
REQ-004 Parameter SIZE_W, default 2, size field width.
REQ-005 Parameter A_DEPTH, default 2, A queue entries; SHALL be >= 1.
REQ-006 Parameter D_DEPTH, default 2, D queue entries; SHALL be >= 1.
REQ-007 Parameter FLOW, default 0; 1 = empty queue forwards input to output combinationally.
REQ-008 Parameter PIPE, default 0; 1 = full queue accepts input in the same cycle its head pops.
REQ-009 clock  in  1  sole clock, rising edge.
REQ-010 reset  in  1  asynchronous, active-high reset.
REQ-011 a_in_valid / a_in_ready  in / out  1 each  upstream A handshake.
REQ-012 a_in_bits  in  A_W  packed {opcode[3], param[3], size, source, address, mask[DATA_W/8], data, corrupt[1]}.
REQ-013 a_out_valid / a_out_ready  out / in  1 each  downstream A handshake.
REQ-014 a_out_bits  out  A_W  same packing as a_in_bits.
REQ-015 d_in_valid / d_in_ready  in / out  1 each  downstream-side D handshake.
REQ-016 d_in_bits  in  D_W  packed {opcode[3], param[2], size, source, sink[1], denied[1], data, corrupt[1]}.
REQ-017 d_out_valid / d_out_ready  out / in  1 each  upstream-side D handshake.
REQ-018 d_out_bits  out  D_W  same packing as d_in_bits.
REQ-019 a_count, d_count  out  clog2(DEPTH+1)  current occupancy of each queue.
REQ-020 idle  out  1  high when both queues empty.

Function
REQ-021 Each channel SHALL be an independent FIFO; beats leave in arrival order, bits unmodified.
REQ-022 Transfer occurs on a port only when valid and ready are both high at a rising clock edge.
REQ-023 in_ready = (count < DEPTH), or, with PIPE=1, additionally (count == DEPTH and out_ready).
REQ-024 out_valid = (count > 0), or, with FLOW=1, additionally (count == 0 and in_valid).
REQ-025 FLOW=0: latency in->out SHALL be exactly 1 cycle when the queue is empty.
REQ-026 FLOW=1 and count==0: out_bits = in_bits same cycle; if out_ready, beat SHALL NOT be stored and count stays 0.
REQ-027 Simultaneous push and pop: count unchanged; write and read pointers both advance.
REQ-028 Pointers SHALL wrap from DEPTH-1 to 0 for any DEPTH, including non-powers of two.
REQ-029 Full queue without PIPE: in_ready low; no overwrite; count SHALL never exceed DEPTH.
REQ-030 Empty queue without FLOW: out_valid low; out_bits don't-care; count SHALL never underflow.
REQ-031 out_bits SHALL remain stable while out_valid is high and out_ready is low.
REQ-032 Storage SHALL not be reset; only pointers and counts are.
REQ-033 idle = (a_count == 0) and (d_count == 0), combinational from registers.

Reset
REQ-034 On reset assertion, asynchronously: pointers = 0, a_count = d_count = 0, a_out_valid = d_out_valid = 0 (FLOW=1: follows in_valid), a_in_ready = d_in_ready = 1, idle = 1.
REQ-035 Beats resident at reset assertion SHALL be discarded; first edge after deassertion SHALL accept a valid beat normally.

Verification
REQ-036 DEPTH=2, FLOW=0: push beat address 0x0040, data 0xDEADBEEF, out_ready=1 -> a_out_valid one cycle later with identical bits, a_count 1 -> 0.
REQ-037 DEPTH=2, out_ready=0: push 3 beats -> a_in_ready low after 2nd, a_count = 2, third held; raise out_ready -> beats emerge in order 1,2,3.
REQ-038 DEPTH=2, PIPE=1, full, out_ready=1, in_valid=1 -> a_in_ready=1, push and pop same cycle, a_count stays 2.
REQ-039 D_DEPTH=3 (non-power-of-two): stream 10 beats with random out_ready stalls -> order preserved across pointer wrap, d_count <= 3 always.
REQ-040 FLOW=1, empty, d_in_valid=1, d_out_ready=1, source=5 -> d_out_valid and source=5 same cycle, d_count stays 0.
REQ-041 Reset asserted mid-cycle with a_count=2 -> a_count=0, a_out_valid=0, idle=1 immediately, before next clock edge.
